// File: rtl/alu_sequencer_pkg.sv
// Shared opcode and state encodings for the risc-me ALU sequencer.
package alu_sequencer_pkg;

  // Opcodes 0..3 double as ALU mode codes.
  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_LDI  = 3'd4,
    OP_JZ   = 3'd5,
    OP_JC   = 3'd6,
    OP_HALT = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_OPERAND   = 3'd4,
    S_HALT      = 3'd5
  } state_e;

  localparam int         NREGS_DEF    = 4;
  localparam logic [7:0] RESET_PC_DEF = 8'h00;

  function automatic logic is_alu_op(input opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// General register file: two operand read ports, one debug read port,
// one synchronous write port, synchronous active-low clear.
module alu_sequencer_regfile #(
  parameter int NREGS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] ra_a_i,
  input  logic [1:0] ra_b_i,
  input  logic [1:0] ra_dbg_i,
  output logic [7:0] rd_a_o,
  output logic [7:0] rd_b_o,
  output logic [7:0] rd_dbg_o,
  input  logic       we_i,
  input  logic [1:0] waddr_i,
  input  logic [7:0] wdata_i
);

  logic [7:0] regs_q [NREGS];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= 8'h00;
      end
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rd_a_o   = regs_q[ra_a_i];
  assign rd_b_o   = regs_q[ra_b_i];
  assign rd_dbg_o = regs_q[ra_dbg_i];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction fetch/decode controller driving the external 8-bit ALU and
// writing its registered results back to the register file.
//
// state     | meaning
// FETCH     | latch instruction at pc, pc+1
// DECODE    | ALU op: latch operands/mode; LDI/JZ/JC: to OPERAND; HALT: stop
// EXECUTE   | alu_enable high for this single cycle
// WRITEBACK | rd <= alu_out, capture Z/C
// OPERAND   | consume byte at pc: load rd or conditional jump
// HALT      | frozen until reset
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int         NREGS    = NREGS_DEF,
  parameter logic [7:0] RESET_PC = RESET_PC_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  output logic       alu_enable,
  output logic [2:0] alu_mode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_out,
  input  logic       alu_zero,
  input  logic       alu_carry,
  output logic       halted,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_data
);

  state_e     state_q;
  opcode_e    op_q;
  logic [1:0] rd_q;
  logic [1:0] rs_q;
  logic [7:0] pc_q;
  logic [7:0] pc_d;
  logic       z_q;
  logic       c_q;
  logic       alu_enable_q;
  logic [2:0] alu_mode_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic       halted_q;

  logic [7:0] rf_rd_a;
  logic [7:0] rf_rd_b;
  logic       rf_we;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       branch_taken;

  // Instruction bit 4 carries no meaning.
  logic unused_ir_bit;
  assign unused_ir_bit = imem_data[4];

  alu_sequencer_regfile #(
    .NREGS(NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra_a_i   (rd_q),
    .ra_b_i   (rs_q),
    .ra_dbg_i (dbg_sel),
    .rd_a_o   (rf_rd_a),
    .rd_b_o   (rf_rd_b),
    .rd_dbg_o (dbg_data),
    .we_i     (rf_we),
    .waddr_i  (rf_waddr),
    .wdata_i  (rf_wdata)
  );

  assign branch_taken = ((op_q == OP_JZ) && z_q) || ((op_q == OP_JC) && c_q);

  always_comb begin
    pc_d = pc_q;
    case (state_q)
      S_FETCH:   pc_d = pc_q + 8'd1;
      S_OPERAND: pc_d = branch_taken ? imem_data : pc_q + 8'd1;
      default:   pc_d = pc_q;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = rd_q;
    rf_wdata = alu_out;
    if (state_q == S_WRITEBACK) begin
      rf_we = 1'b1;
    end else if ((state_q == S_OPERAND) && (op_q == OP_LDI)) begin
      rf_we    = 1'b1;
      rf_wdata = imem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      op_q         <= OP_ADD;
      rd_q         <= 2'd0;
      rs_q         <= 2'd0;
      z_q          <= 1'b0;
      c_q          <= 1'b0;
      alu_enable_q <= 1'b0;
      alu_mode_q   <= 3'd0;
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      halted_q     <= 1'b0;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        S_FETCH: begin
          op_q    <= opcode_e'(imem_data[7:5]);
          rd_q    <= imem_data[3:2];
          rs_q    <= imem_data[1:0];
          state_q <= S_DECODE;
        end
        S_DECODE: begin
          if (is_alu_op(op_q)) begin
            alu_a_q      <= rf_rd_a;
            alu_b_q      <= rf_rd_b;
            alu_mode_q   <= op_q;
            alu_enable_q <= 1'b1;
            state_q      <= S_EXECUTE;
          end else if (op_q == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= S_HALT;
          end else begin
            state_q <= S_OPERAND;
          end
        end
        S_EXECUTE: begin
          alu_enable_q <= 1'b0;
          state_q      <= S_WRITEBACK;
        end
        S_WRITEBACK: begin
          // The ALU flags have no reset, so a local copy is kept.
          z_q     <= alu_zero;
          c_q     <= alu_carry;
          state_q <= S_FETCH;
        end
        S_OPERAND: begin
          state_q <= S_FETCH;
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          alu_enable_q <= 1'b0;
          state_q      <= S_FETCH;
        end
      endcase
    end
  end

  assign imem_addr  = pc_q;
  assign alu_enable = alu_enable_q;
  assign alu_mode   = alu_mode_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign halted     = halted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: ROM + ALU models, ALU-request
// scoreboard, table-driven arithmetic/branch vectors and hand-written corner cases.
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] imem_addr;
  logic [7:0] imem_data;
  logic       alu_enable;
  logic [2:0] alu_mode;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic       alu_carry;
  logic       halted;
  logic [1:0] dbg_sel;
  logic [7:0] dbg_data;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .alu_enable (alu_enable),
    .alu_mode   (alu_mode),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_out    (alu_out),
    .alu_zero   (alu_zero),
    .alu_carry  (alu_carry),
    .halted     (halted),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data)
  );

  logic [7:0] rom [256];
  assign imem_data = rom[imem_addr];

  // ALU model: registers result/flags on an enabled edge; AND/OR keep carry.
  logic [8:0] alu_t;
  initial begin
    alu_out   = 8'h00;
    alu_zero  = 1'b0;
    alu_carry = 1'b0;
  end
  always @(posedge clk) begin
    if (alu_enable) begin
      case (alu_mode)
        3'd0:    alu_t = {1'b0, alu_a} + {1'b0, alu_b};
        3'd1:    alu_t = {1'b0, alu_a} - {1'b0, alu_b};
        3'd2:    alu_t = {alu_carry, alu_a & alu_b};
        3'd3:    alu_t = {alu_carry, alu_a | alu_b};
        default: alu_t = {alu_carry, 8'h00};
      endcase
      alu_out   <= alu_t[7:0];
      alu_carry <= alu_t[8];
      alu_zero  <= (alu_t[7:0] == 8'h00);
    end
  end

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0] mode;
    logic [7:0] a;
    logic [7:0] b;
  } alu_req_t;

  alu_req_t exp_q[$];
  alu_req_t got_req;
  logic     en_prev = 1'b0;

  always @(negedge clk) begin
    if (alu_enable) begin
      checks++;
      if (en_prev) begin
        errors++;
        $display("FAIL alu_enable_width: high two cycles running, required one cycle");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL alu_unexpected: mode=%0d a=%0h b=%0h with no request expected",
                 alu_mode, alu_a, alu_b);
      end else begin
        got_req = exp_q.pop_front();
        if ({alu_mode, alu_a, alu_b} !== got_req) begin
          errors++;
          $display("FAIL alu_request: got mode=%0d a=%0h b=%0h, expected mode=%0d a=%0h b=%0h",
                   alu_mode, alu_a, alu_b, got_req.mode, got_req.a, got_req.b);
        end
      end
    end
    en_prev = alu_enable;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
    dbg_sel = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 256; i++) rom[i] = 8'hE0;
  endtask

  // Leaves the bench at a negedge with rst_n released; DUT is in FETCH (cycle 0).
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       z;
    logic       c;
  } vec_t;

  vec_t       vecs[10];
  logic [7:0] v;
  logic [7:0] exp_pc;
  logic [7:0] prev_addr;
  bit         found;

  initial begin
    rst_n   = 1'b0;
    dbg_sel = 2'd0;
    rom_clear();

    // Flags of AND/OR rows follow the carry left by the row before.
    vecs[0] = '{3'd0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
    vecs[1] = '{3'd1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b1};
    vecs[2] = '{3'd2, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{3'd0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{3'd1, 8'hA5, 8'hA5, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{3'd3, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{3'd3, 8'h50, 8'h0A, 8'h5A, 1'b0, 1'b0};
    vecs[7] = '{3'd0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[8] = '{3'd2, 8'hFF, 8'h3C, 8'h3C, 1'b0, 1'b1};
    vecs[9] = '{3'd1, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_imem_addr", {24'd0, imem_addr}, 32'h00);
    chk("rst_alu_enable", {31'd0, alu_enable}, 32'd0);
    chk("rst_alu_mode", {29'd0, alu_mode}, 32'd0);
    chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], v);
      chk("rst_reg", {24'd0, v}, 32'd0);
    end

    // Table: LDI r0,a; LDI r1,b; OP r0,r1; JZ 40; JC 50; HALT.
    // The halt address encodes the flags: 0A Z0C0, 51 Z0C1, 43 Z1C0, 61 Z1C1.
    for (int i = 0; i < 10; i++) begin
      rom_clear();
      rom[0] = 8'h80; rom[1] = vecs[i].a;
      rom[2] = 8'h84; rom[3] = vecs[i].b;
      rom[4] = {vecs[i].op, 5'b00001};
      rom[5] = 8'hA0; rom[6] = 8'h40;
      rom[7] = 8'hC0; rom[8] = 8'h50;
      rom[8'h40] = 8'hC0; rom[8'h41] = 8'h60;
      exp_q.push_back('{vecs[i].op, vecs[i].a, vecs[i].b});
      do_reset();
      run_to_halt(200);
      read_reg(2'd0, v);
      chk("vec_result", {24'd0, v}, {24'd0, vecs[i].r});
      read_reg(2'd1, v);
      chk("vec_rs_kept", {24'd0, v}, {24'd0, vecs[i].b});
      case ({vecs[i].z, vecs[i].c})
        2'b00:   exp_pc = 8'h0A;
        2'b01:   exp_pc = 8'h51;
        2'b10:   exp_pc = 8'h43;
        default: exp_pc = 8'h61;
      endcase
      chk("vec_flags_pc", {24'd0, imem_addr}, {24'd0, exp_pc});
    end

    // Latency: LDI r0,5; LDI r1,3; ADD r0,r1; OR r2,r2; HALT at 06
    rom_clear();
    rom[0] = 8'h80; rom[1] = 8'h05;
    rom[2] = 8'h84; rom[3] = 8'h03;
    rom[4] = 8'h01;
    rom[5] = 8'h6A;
    exp_q.push_back('{3'd0, 8'h05, 8'h03});
    exp_q.push_back('{3'd3, 8'h00, 8'h00});
    do_reset();
    for (int c = 0; c < 18; c++) begin
      chk("lat_alu_enable", {31'd0, alu_enable}, {31'd0, (c == 8 || c == 12)});
      chk("lat_halted", {31'd0, halted}, {31'd0, (c >= 16)});
      if (c == 9) begin
        read_reg(2'd0, v);
        chk("lat_r0_before_wb", {24'd0, v}, 32'h05);
      end
      if (c == 10) begin
        read_reg(2'd0, v);
        chk("lat_r0_after_wb", {24'd0, v}, 32'h08);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 20; c++) begin
      chk("halt_pc", {24'd0, imem_addr}, 32'h07);
      chk("halt_alu_enable", {31'd0, alu_enable}, 32'd0);
      chk("halt_flag", {31'd0, halted}, 32'd1);
      read_reg(2'd0, v);
      chk("halt_r0", {24'd0, v}, 32'h08);
      @(negedge clk);
    end

    // Reset asserted while EXECUTE is in progress
    rom_clear();
    rom[0] = 8'h80; rom[1] = 8'h05;
    rom[2] = 8'h84; rom[3] = 8'h03;
    rom[4] = 8'h01;
    exp_q.push_back('{3'd0, 8'h05, 8'h03});
    do_reset();
    found = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (alu_enable) found = 1'b1;
      else @(negedge clk);
    end
    chk("mid_exec_reached", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_alu_enable", {31'd0, alu_enable}, 32'd0);
    chk("mid_rst_pc", {24'd0, imem_addr}, 32'h00);
    chk("mid_rst_alu_mode", {29'd0, alu_mode}, 32'd0);
    chk("mid_rst_alu_a", {24'd0, alu_a}, 32'd0);
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    for (int r = 0; r < 4; r++) begin
      read_reg(r[1:0], v);
      chk("mid_rst_reg", {24'd0, v}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_alu_enable", {31'd0, alu_enable}, 32'd0);
    chk("post_rst_fetch_pc", {24'd0, imem_addr}, 32'h01);

    // rd==rs, JZ taken to F0, ORs up to FE, LDI operand at FF, pc wraps to 00
    rom_clear();
    rom[0] = 8'h88; rom[1] = 8'hA5;
    rom[2] = 8'h2A;
    rom[3] = 8'hA0; rom[4] = 8'hF0;
    for (int a = 8'hF0; a <= 8'hFD; a++) rom[a] = 8'h65;
    rom[8'hFE] = 8'h8C; rom[8'hFF] = 8'h77;
    exp_q.push_back('{3'd1, 8'hA5, 8'hA5});
    for (int k = 0; k < 14; k++) exp_q.push_back('{3'd3, 8'h00, 8'h00});
    do_reset();
    found     = 1'b0;
    prev_addr = imem_addr;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (prev_addr == 8'hFF && imem_addr == 8'h00) found = 1'b1;
      prev_addr = imem_addr;
    end
    chk("wrap_reached", {31'd0, found}, 32'd1);
    read_reg(2'd3, v);
    chk("wrap_ldi_operand", {24'd0, v}, 32'h77);
    read_reg(2'd2, v);
    chk("sub_self_zero", {24'd0, v}, 32'h00);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk("scoreboard_drain", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Control-side initiator for the 8-bit ALU in the risc-me core. It fetches 8-bit instructions, decodes them, and drives the ALU's enable/mode/operand inputs.
- It consumes the ALU's registered result and flags, and writes results back to a 4-entry register file.
- It also handles immediate loads, conditional jumps and halt.
- Sits between instruction memory (async ROM) and the ALU.

Parameters:
- NREGS, 4, number of general registers. Fixed at 4 because rd/rs fields are 2 bits.
- RESET_PC, 8'h00, PC value loaded on reset.

Ports:
- clk  input  1  core clock; all state updates on posedge.
- rst_n  input  1  synchronous active-low reset, sampled at posedge clk.
- imem_addr  output  8  instruction memory address. Combinational from PC.
- imem_data  input  8  instruction memory read data. Asynchronous ROM: valid in the same cycle as imem_addr.
- alu_enable  output  1  ALU enable strobe. High for exactly one cycle per ALU instruction.
- alu_mode  output  3  ALU mode. Uses the `OP_* codes.
- alu_a  output  8  ALU operand A, taken from register rd.
- alu_b  output  8  ALU operand B, taken from register rs.
- alu_out  input  8  ALU result.
- alu_zero  input  1  ALU zero flag.
- alu_carry  input  1  ALU carry/borrow flag.
- halted  output  1  High while in HALT.
- dbg_sel  input  2  register-file debug read select.
- dbg_data  output  8  contents of register dbg_sel. Combinational.

Behaviour:
- Instruction format: [7:5] opcode, [4] unused, [3:2] rd, [1:0] rs.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR: rd <= rd op rs. Opcode value equals the ALU mode code (`OP_ADD=0, `OP_SUB=1, `OP_AND=2, `OP_OR=3).
  - 4 LDI: rd <= next byte.
  - 5 JZ: if Z, pc <= next byte.
  - 6 JC: if C, pc <= next byte.
  - 7 HALT.
- Reset (rst_n=0 at a posedge, from any state, including mid-EXECUTE):
  - state=FETCH, pc=RESET_PC, IR=0, all regs=0, Z=C=0.
  - alu_enable=0, alu_mode=0, alu_a=alu_b=0, halted=0.
  - Outputs reach these values at that same edge.
- FETCH:
  - imem_addr=pc; IR<=imem_data; pc<=pc+1 (mod 256, 8'hFF wraps to 8'h00).
  - Next state: DECODE.
- DECODE:
  - ALU opcodes: alu_a<=reg[rd], alu_b<=reg[rs], alu_mode<=opcode; go to EXECUTE.
  - LDI/JZ/JC: go to OPERAND.
  - HALT: go to HALT.
- EXECUTE:
  - alu_enable=1 for this single cycle; operands and mode are stable. The ALU registers its result at the closing posedge.
  - Next state: WRITEBACK.
- WRITEBACK:
  - alu_enable=0; reg[rd]<=alu_out; Z<=alu_zero; C<=alu_carry.
  - The ALU leaves carry unchanged on AND/OR, so the local C mirrors the retained value.
  - Next state: FETCH.
- OPERAND:
  - imem_addr=pc.
  - LDI: reg[rd]<=imem_data; pc<=pc+1. Flags unchanged.
  - JZ/JC: pc<=imem_data if the respective local flag is 1, else pc<=pc+1.
  - Next state: FETCH.
- HALT:
  - halted=1; pc and regs frozen; alu_enable=0. Leaves only on reset.
- Latency:
  - ALU instruction: 4 cycles (F, D, E, W).
  - LDI/JZ/JC: 3 cycles.
  - HALT entered 2 cycles after its fetch.
- Flags:
  - The controller holds its own Z/C copies because the ALU flags have no reset.
  - Only WRITEBACK updates Z/C.
- alu_enable must never be high outside EXECUTE. This includes the cycle after reset deassertion.
- rd==rs is legal (e.g. SUB r1,r1 gives 0 with Z=1).
- Operand fetch at pc=8'hFF wraps: the operand byte is read from 8'hFF, and pc becomes 8'h00 when not jumping.

Decomposition:
- parameters.v (shared):
  - existing `OP_ADD/`OP_SUB/`OP_AND/`OP_OR;
  - new `OP_LDI=4, `OP_JZ=5, `OP_JC=6, `OP_HALT=7;
  - state encodings `S_FETCH, `S_DECODE, `S_EXECUTE, `S_WRITEBACK, `S_OPERAND, `S_HALT.
- Sub-module regfile:
  - 4x8, two combinational read ports (rd, rs) plus a third for dbg_sel;
  - one synchronous write port with write enable;
  - synchronous active-low clear.

Test Plan:
- LDI r0,5; LDI r1,3; ADD r0,r1 -> dbg r0=8; alu_enable high exactly 1 cycle with alu_mode=0, alu_a=5, alu_b=3; ADD completes 4 cycles after its fetch; Z=0, C=0.
- LDI r0,3; LDI r1,5; SUB r0,r1; JC 8'h20 -> r0=8'hFE, C=1, pc=8'h20 after jump. Repeat with JZ -> not taken, pc=fall-through address.
- LDI r2,8'hA5; SUB r2,r2; JZ 8'h10 -> r2=0, Z=1, pc=8'h10. Then AND r2,r2 -> C keeps its prior value.
- LDI r3,8'hFF; LDI r0,1; ADD r3,r0 -> r3=0, Z=1, C=1.
- Program ending in HALT at 8'h06 -> halted=1 from 2 cycles after the fetch; pc, regs and alu_enable stay constant for 20 cycles.
- Assert rst_n=0 during EXECUTE -> at the next posedge alu_enable=0, pc=0, all regs=0, state=FETCH. Separately: NOP-like ORs filling to 8'hFF -> pc wraps to 8'h00.
